// File: rtl/player_motion_ctrl_if.sv
// Control, collision and motion-state signals of the player motion controller.
// The master side drives controls and collisions; the slave side returns motion state.
interface player_motion_ctrl_if;
    logic              i_game_tick;
    logic              i_move_left;
    logic              i_move_right;
    logic              i_jump;
    logic              i_on_ground;
    logic [9:0]        i_support_y;
    logic              i_hit_ceiling;
    logic              i_hit_left_wall;
    logic              i_hit_right_wall;
    logic              i_freeze;
    logic [9:0]        o_player_x;
    logic [9:0]        o_player_y;
    logic signed [5:0] o_vx;
    logic signed [7:0] o_vy;
    logic [1:0]        o_state;
    logic              o_jump_start_pulse;
    logic              o_jump_landed_pulse;

    modport master (
        output i_game_tick, i_move_left, i_move_right, i_jump, i_on_ground,
               i_support_y, i_hit_ceiling, i_hit_left_wall, i_hit_right_wall, i_freeze,
        input  o_player_x, o_player_y, o_vx, o_vy, o_state,
               o_jump_start_pulse, o_jump_landed_pulse
    );

    modport slave (
        input  i_game_tick, i_move_left, i_move_right, i_jump, i_on_ground,
               i_support_y, i_hit_ceiling, i_hit_left_wall, i_hit_right_wall, i_freeze,
        output o_player_x, o_player_y, o_vx, o_vy, o_state,
               o_jump_start_pulse, o_jump_landed_pulse
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Platformer player motion: horizontal accel/friction, jump with coyote time and
// input buffering, gravity and landing, all advanced once per unfrozen game tick.
module player_motion_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int PLAYER_W     = 16,
    parameter int PLAYER_H     = 16,
    parameter int START_X      = 20,
    parameter int START_Y      = 344,
    parameter int MAX_HSPD     = 4,
    parameter int H_ACCEL      = 1,
    parameter int JUMP_VEL     = 10,
    parameter int JUMP_CUT     = 3,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 8,
    parameter int COYOTE_TICKS = 4,
    parameter int JBUF_TICKS   = 4
) (
    input logic                 clk,
    input logic                 rst,
    player_motion_ctrl_if.slave bus
);
    // state     | meaning
    // ST_GROUND | standing on support, y snapped to support_y - PLAYER_H
    // ST_RISE   | ascending after a jump launch, vy < 0
    // ST_FALL   | airborne and descending (or walked off a ledge)
    typedef enum logic [1:0] {ST_GROUND = 2'd0, ST_RISE = 2'd1, ST_FALL = 2'd2} state_t;

    localparam logic signed [6:0]  C_HSPD    = 7'(MAX_HSPD);
    localparam logic signed [6:0]  C_HACC    = 7'(H_ACCEL);
    localparam logic signed [11:0] C_X_MAX   = 12'(SCREEN_W - PLAYER_W);
    localparam logic [9:0]         C_X_MAX10 = 10'(SCREEN_W - PLAYER_W);
    localparam logic signed [11:0] C_Y_MAX   = 12'sd1023;
    localparam logic signed [11:0] C_PH      = 12'(PLAYER_H);
    localparam logic signed [11:0] C_JVEL    = 12'(JUMP_VEL);
    localparam logic signed [11:0] C_JCUT    = 12'(JUMP_CUT);
    localparam logic signed [11:0] C_GRAV    = 12'(GRAVITY);
    localparam logic signed [11:0] C_MFALL   = 12'(MAX_FALL);
    localparam logic [7:0]         C_COYOTE  = 8'(COYOTE_TICKS);
    localparam logic [7:0]         C_JBUF    = 8'(JBUF_TICKS);

    logic [9:0]        r_x, r_y;
    logic signed [5:0] r_vx;
    logic signed [7:0] r_vy;
    state_t            r_state;
    logic [7:0]        r_jbuf, r_coyote;
    logic              r_jump_prev, r_start_pulse, r_land_pulse;

    logic              w_tick_en;
    logic signed [6:0] w_vx_ext, w_vx_acc;
    logic signed [11:0] w_x_sum;
    logic [9:0]        w_x_next;
    logic signed [5:0] w_vx_next;

    logic              w_edge, w_jump_start, w_land, w_land_evt;
    logic [7:0]        w_jbuf_next, w_coyote_next;
    logic signed [11:0] w_y_ext, w_vy_ext, w_gnd_y, w_vy_cut, w_y_calc, w_vy_calc;
    logic [9:0]        w_y_next;
    logic signed [7:0] w_vy_next;
    state_t            w_state_next;

    assign w_tick_en = bus.i_game_tick && !bus.i_freeze;

    always_comb begin
        w_vx_ext = {r_vx[5], r_vx};
        w_vx_acc = w_vx_ext;
        if (bus.i_move_left && !bus.i_move_right) begin
            w_vx_acc = w_vx_ext - C_HACC;
            if (w_vx_acc < -C_HSPD) w_vx_acc = -C_HSPD;
        end else if (bus.i_move_right && !bus.i_move_left) begin
            w_vx_acc = w_vx_ext + C_HACC;
            if (w_vx_acc > C_HSPD) w_vx_acc = C_HSPD;
        end else if (w_vx_ext > C_HACC) begin
            w_vx_acc = w_vx_ext - C_HACC;
        end else if (w_vx_ext < -C_HACC) begin
            w_vx_acc = w_vx_ext + C_HACC;
        end else begin
            w_vx_acc = '0;
        end
        if ((w_vx_acc < 0 && bus.i_hit_left_wall) || (w_vx_acc > 0 && bus.i_hit_right_wall))
            w_vx_acc = '0;

        w_vx_next = w_vx_acc[5:0];
        w_x_sum   = $signed({2'b00, r_x}) + {{5{w_vx_acc[6]}}, w_vx_acc};
        w_x_next  = w_x_sum[9:0];
        // Hitting a screen edge kills horizontal momentum as well as clamping x.
        if (w_x_sum < 0) begin
            w_x_next  = '0;
            w_vx_next = '0;
        end else if (w_x_sum > C_X_MAX) begin
            w_x_next  = C_X_MAX10;
            w_vx_next = '0;
        end
    end

    always_comb begin
        w_edge        = bus.i_jump && !r_jump_prev;
        // A fresh press may launch on its own tick; the buffer covers later ticks.
        w_jump_start  = (w_edge || (r_jbuf != '0)) && (bus.i_on_ground || (r_coyote != '0))
                        && (r_state != ST_RISE);
        w_land        = bus.i_on_ground && (r_state != ST_GROUND) && !r_vy[7];
        w_jbuf_next   = w_edge ? C_JBUF : ((r_jbuf != '0) ? r_jbuf - 8'd1 : '0);
        w_coyote_next = bus.i_on_ground ? C_COYOTE : ((r_coyote != '0) ? r_coyote - 8'd1 : '0);
        w_y_ext       = $signed({2'b00, r_y});
        w_vy_ext      = {{4{r_vy[7]}}, r_vy};
        w_gnd_y       = $signed({2'b00, bus.i_support_y}) - C_PH;
        w_vy_cut      = w_vy_ext;
        w_y_calc      = w_y_ext;
        w_vy_calc     = w_vy_ext;
        w_state_next  = r_state;
        w_land_evt    = 1'b0;

        if (w_jump_start) begin
            w_y_calc      = w_y_ext - C_JVEL;
            w_vy_calc     = -C_JVEL;
            w_state_next  = ST_RISE;
            w_jbuf_next   = '0;
            w_coyote_next = '0;
        end else if (w_land) begin
            w_y_calc     = w_gnd_y;
            w_vy_calc    = '0;
            w_state_next = ST_GROUND;
            w_land_evt   = 1'b1;
        end else begin
            case (r_state)
                ST_GROUND: begin
                    w_vy_calc = '0;
                    if (bus.i_on_ground) w_y_calc = w_gnd_y;
                    else                 w_state_next = ST_FALL;
                end
                ST_RISE: begin
                    if (bus.i_hit_ceiling && r_vy[7]) begin
                        w_vy_calc    = '0;
                        w_state_next = ST_FALL;
                    end else begin
                        if (!bus.i_jump && w_vy_ext < -C_JCUT) w_vy_cut = -C_JCUT;
                        w_y_calc  = w_y_ext + w_vy_cut;
                        w_vy_calc = w_vy_cut + C_GRAV;
                        if (!w_vy_calc[11]) w_state_next = ST_FALL;
                    end
                end
                default: begin
                    w_y_calc  = w_y_ext + w_vy_ext;
                    w_vy_calc = w_vy_ext + C_GRAV;
                    if (w_vy_calc > C_MFALL) w_vy_calc = C_MFALL;
                end
            endcase
        end

        w_y_next  = w_y_calc[9:0];
        w_vy_next = w_vy_calc[7:0];
        if (w_y_calc < 0) begin
            w_y_next  = '0;
            w_vy_next = '0;
        end else if (w_y_calc > C_Y_MAX) begin
            w_y_next = 10'd1023;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x           <= 10'(START_X);
            r_y           <= 10'(START_Y);
            r_vx          <= '0;
            r_vy          <= '0;
            r_state       <= ST_GROUND;
            r_jbuf        <= '0;
            r_coyote      <= '0;
            r_jump_prev   <= 1'b0;
            r_start_pulse <= 1'b0;
            r_land_pulse  <= 1'b0;
        end else begin
            r_start_pulse <= w_tick_en && w_jump_start;
            r_land_pulse  <= w_tick_en && w_land_evt;
            if (w_tick_en) begin
                r_x         <= w_x_next;
                r_vx        <= w_vx_next;
                r_y         <= w_y_next;
                r_vy        <= w_vy_next;
                r_state     <= w_state_next;
                r_jbuf      <= w_jbuf_next;
                r_coyote    <= w_coyote_next;
                r_jump_prev <= bus.i_jump;
            end
        end
    end

    assign bus.o_player_x          = r_x;
    assign bus.o_player_y          = r_y;
    assign bus.o_vx                = r_vx;
    assign bus.o_vy                = r_vy;
    assign bus.o_state             = r_state;
    assign bus.o_jump_start_pulse  = r_start_pulse;
    assign bus.o_jump_landed_pulse = r_land_pulse;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus randomized play checked
// against an integer reference model of the motion rules.
module tb_player_motion_ctrl;
    localparam int SCREEN_W = 640, PLAYER_W = 16, PLAYER_H = 16;
    localparam int START_X = 20, START_Y = 344;
    localparam int MAX_HSPD = 4, H_ACCEL = 1, JUMP_VEL = 10, JUMP_CUT = 3;
    localparam int GRAVITY = 1, MAX_FALL = 8, COYOTE_TICKS = 4, JBUF_TICKS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    player_motion_ctrl_if bus();

    player_motion_ctrl #(
        .SCREEN_W(SCREEN_W), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H),
        .START_X(START_X), .START_Y(START_Y), .MAX_HSPD(MAX_HSPD), .H_ACCEL(H_ACCEL),
        .JUMP_VEL(JUMP_VEL), .JUMP_CUT(JUMP_CUT), .GRAVITY(GRAVITY), .MAX_FALL(MAX_FALL),
        .COYOTE_TICKS(COYOTE_TICKS), .JBUF_TICKS(JBUF_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model (0=ground, 1=rise, 2=fall)
    int m_x, m_y, m_vx, m_vy, m_st, m_jbuf, m_coy;
    bit m_prev, m_sp, m_lp;

    function automatic void m_reset();
        m_x = START_X; m_y = START_Y; m_vx = 0; m_vy = 0; m_st = 0;
        m_jbuf = 0; m_coy = 0; m_prev = 0; m_sp = 0; m_lp = 0;
    endfunction

    function automatic void model_clock(bit en);
        int tgt, nvx, nx, ny, nvy, nst, njb, nco, v, gy;
        bit jl, jr, jj, og, jedge, can_jump;
        m_sp = 0; m_lp = 0;
        if (!en) return;
        jl = bus.i_move_left; jr = bus.i_move_right; jj = bus.i_jump; og = bus.i_on_ground;
        gy = int'(bus.i_support_y) - PLAYER_H;

        tgt = (jl && !jr) ? -1 : ((jr && !jl) ? 1 : 0);
        if (tgt != 0) begin
            nvx = m_vx + tgt * H_ACCEL;
            if (nvx > MAX_HSPD) nvx = MAX_HSPD;
            if (nvx < -MAX_HSPD) nvx = -MAX_HSPD;
        end else if (m_vx > 0) nvx = (m_vx > H_ACCEL) ? m_vx - H_ACCEL : 0;
        else nvx = (m_vx < -H_ACCEL) ? m_vx + H_ACCEL : 0;
        if ((nvx < 0 && bus.i_hit_left_wall) || (nvx > 0 && bus.i_hit_right_wall)) nvx = 0;
        nx = m_x + nvx;
        if (nx < 0) begin nx = 0; nvx = 0; end
        else if (nx > SCREEN_W - PLAYER_W) begin nx = SCREEN_W - PLAYER_W; nvx = 0; end

        jedge = jj && !m_prev;
        can_jump = (jedge || m_jbuf > 0) && (og || m_coy > 0) && (m_st != 1);
        njb = jedge ? JBUF_TICKS : ((m_jbuf > 0) ? m_jbuf - 1 : 0);
        nco = og ? COYOTE_TICKS : ((m_coy > 0) ? m_coy - 1 : 0);
        ny = m_y; nvy = m_vy; nst = m_st;
        if (can_jump) begin
            ny = m_y - JUMP_VEL; nvy = -JUMP_VEL; nst = 1; njb = 0; nco = 0; m_sp = 1;
        end else if (og && m_st != 0 && m_vy >= 0) begin
            ny = gy; nvy = 0; nst = 0; m_lp = 1;
        end else if (m_st == 0) begin
            nvy = 0;
            if (og) ny = gy; else nst = 2;
        end else if (m_st == 1) begin
            if (bus.i_hit_ceiling && m_vy < 0) begin
                nvy = 0; nst = 2;
            end else begin
                v = (!jj && m_vy < -JUMP_CUT) ? -JUMP_CUT : m_vy;
                ny = m_y + v; nvy = v + GRAVITY;
                if (nvy >= 0) nst = 2;
            end
        end else begin
            ny = m_y + m_vy;
            nvy = (m_vy + GRAVITY > MAX_FALL) ? MAX_FALL : m_vy + GRAVITY;
        end
        if (ny < 0) begin ny = 0; nvy = 0; end
        else if (ny > 1023) ny = 1023;

        m_x = nx; m_vx = nvx; m_y = ny; m_vy = nvy; m_st = nst;
        m_jbuf = njb; m_coy = nco; m_prev = jj;
    endfunction

    task automatic cyc(input logic t);
        bus.i_game_tick = t;
        @(posedge clk);
        model_clock(t && !bus.i_freeze);
        #1;
        bus.i_game_tick = 1'b0;
    endtask

    task automatic test_reset();
        m_reset();
        bus.i_game_tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.i_game_tick = 1'b0;
        n_cmp += 7;
        if (bus.o_player_x !== 10'(START_X)) begin n_fail++; $display("FAIL reset_x got %0d exp %0d", bus.o_player_x, START_X); end
        if (bus.o_player_y !== 10'(START_Y)) begin n_fail++; $display("FAIL reset_y got %0d exp %0d", bus.o_player_y, START_Y); end
        if (bus.o_vx !== 6'sd0) begin n_fail++; $display("FAIL reset_vx got %0d exp 0", bus.o_vx); end
        if (bus.o_vy !== 8'sd0) begin n_fail++; $display("FAIL reset_vy got %0d exp 0", bus.o_vy); end
        if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.o_state); end
        if (bus.o_jump_start_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_spulse got %b exp 0", bus.o_jump_start_pulse); end
        if (bus.o_jump_landed_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_lpulse got %b exp 0", bus.o_jump_landed_pulse); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_walk();
        int exp_vx[6] = '{1, 2, 3, 4, 4, 4};
        int exp_x[6]  = '{21, 23, 26, 30, 34, 38};
        bus.i_on_ground = 1'b1; bus.i_support_y = 10'd360; bus.i_move_right = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1);
            n_cmp += 3;
            if (bus.o_vx !== 6'(exp_vx[i])) begin n_fail++; $display("FAIL walk_vx[%0d] got %0d exp %0d", i, bus.o_vx, exp_vx[i]); end
            if (bus.o_player_x !== 10'(exp_x[i])) begin n_fail++; $display("FAIL walk_x[%0d] got %0d exp %0d", i, bus.o_player_x, exp_x[i]); end
            if (bus.o_player_y !== 10'd344) begin n_fail++; $display("FAIL walk_y[%0d] got %0d exp 344", i, bus.o_player_y); end
        end
        bus.i_move_right = 1'b0;
    endtask

    task automatic test_jump_held(output int apex);
        int n;
        bus.i_jump = 1'b1;
        cyc(1'b1);
        n_cmp += 4;
        if (bus.o_vy !== -8'sd10) begin n_fail++; $display("FAIL held_launch_vy got %0d exp -10", bus.o_vy); end
        if (bus.o_player_y !== 10'd334) begin n_fail++; $display("FAIL held_launch_y got %0d exp 334", bus.o_player_y); end
        if (bus.o_state !== 2'd1) begin n_fail++; $display("FAIL held_launch_state got %0d exp 1", bus.o_state); end
        if (bus.o_jump_start_pulse !== 1'b1) begin n_fail++; $display("FAIL held_spulse got %b exp 1", bus.o_jump_start_pulse); end
        cyc(1'b0);
        n_cmp++;
        if (bus.o_jump_start_pulse !== 1'b0) begin n_fail++; $display("FAIL held_spulse_width got %b exp 0", bus.o_jump_start_pulse); end
        bus.i_on_ground = 1'b0;
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_player_y !== 10'd324) begin n_fail++; $display("FAIL held_y2 got %0d exp 324", bus.o_player_y); end
        if (bus.o_vy !== 8'(m_vy)) begin n_fail++; $display("FAIL held_vy2 got %0d exp %0d", bus.o_vy, m_vy); end
        apex = int'(bus.o_player_y);
        n = 0;
        while (m_st == 1 && n < 30) begin
            cyc(1'b1);
            n++;
            if (int'(bus.o_player_y) < apex) apex = int'(bus.o_player_y);
        end
        n_cmp += 2;
        if (n >= 30) begin n_fail++; $display("FAIL held_rise_timeout got %0d ticks exp <30", n); end
        if (apex != 279) begin n_fail++; $display("FAIL held_apex got %0d exp 279", apex); end
        bus.i_jump = 1'b0; bus.i_on_ground = 1'b1; bus.i_support_y = 10'd360;
        cyc(1'b1);
        n_cmp += 3;
        if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL held_land_state got %0d exp 0", bus.o_state); end
        if (bus.o_player_y !== 10'd344) begin n_fail++; $display("FAIL held_land_y got %0d exp 344", bus.o_player_y); end
        if (bus.o_jump_landed_pulse !== 1'b1) begin n_fail++; $display("FAIL held_lpulse got %b exp 1", bus.o_jump_landed_pulse); end
    endtask

    task automatic test_jump_tap(input int apex_held);
        int apex, n;
        bus.i_jump = 1'b1;
        cyc(1'b1);
        bus.i_jump = 1'b0; bus.i_on_ground = 1'b0;
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_player_y !== 10'd331) begin n_fail++; $display("FAIL tap_y got %0d exp 331", bus.o_player_y); end
        if (bus.o_vy !== -8'sd2) begin n_fail++; $display("FAIL tap_vy got %0d exp -2", bus.o_vy); end
        apex = int'(bus.o_player_y);
        n = 0;
        while (m_st == 1 && n < 30) begin
            cyc(1'b1);
            n++;
            if (int'(bus.o_player_y) < apex) apex = int'(bus.o_player_y);
        end
        n_cmp += 2;
        if (apex != 328) begin n_fail++; $display("FAIL tap_apex got %0d exp 328", apex); end
        if (apex <= apex_held) begin n_fail++; $display("FAIL tap_apex_lower got %0d exp above %0d", apex, apex_held); end
        bus.i_on_ground = 1'b1;
        cyc(1'b1);
    endtask

    task automatic test_coyote();
        int n;
        cyc(1'b1);
        bus.i_on_ground = 1'b0;
        cyc(1'b1);
        n_cmp += 3;
        if (bus.o_state !== 2'd2) begin n_fail++; $display("FAIL walkoff_state got %0d exp 2", bus.o_state); end
        if (bus.o_player_y !== 10'd344) begin n_fail++; $display("FAIL walkoff_y got %0d exp 344", bus.o_player_y); end
        if (bus.o_jump_landed_pulse !== 1'b0) begin n_fail++; $display("FAIL walkoff_lpulse got %b exp 0", bus.o_jump_landed_pulse); end
        cyc(1'b1);
        bus.i_jump = 1'b1;
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_jump_start_pulse !== 1'b1) begin n_fail++; $display("FAIL coyote_spulse got %b exp 1", bus.o_jump_start_pulse); end
        if (bus.o_state !== 2'd1) begin n_fail++; $display("FAIL coyote_state got %0d exp 1", bus.o_state); end
        bus.i_jump = 1'b0; bus.i_on_ground = 1'b1;
        n = 0;
        while (m_st != 0 && n < 40) begin cyc(1'b1); n++; end
        n_cmp++;
        if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL coyote_reland got %0d exp 0", bus.o_state); end
        bus.i_on_ground = 1'b0;
        repeat (COYOTE_TICKS + 1) cyc(1'b1);
        bus.i_jump = 1'b1;
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_jump_start_pulse !== 1'b0) begin n_fail++; $display("FAIL late_spulse got %b exp 0", bus.o_jump_start_pulse); end
        if (bus.o_state !== 2'd2) begin n_fail++; $display("FAIL late_state got %0d exp 2", bus.o_state); end
    endtask

    task automatic test_landing();
        bus.i_jump = 1'b0;
        repeat (JBUF_TICKS) cyc(1'b1);
        bus.i_freeze = 1'b1; bus.i_on_ground = 1'b1; bus.i_support_y = 10'd200;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            n_cmp += 4;
            if (bus.o_player_y !== 10'(m_y)) begin n_fail++; $display("FAIL frz_y got %0d exp %0d", bus.o_player_y, m_y); end
            if (bus.o_vy !== 8'(m_vy)) begin n_fail++; $display("FAIL frz_vy got %0d exp %0d", bus.o_vy, m_vy); end
            if (bus.o_state !== 2'd2) begin n_fail++; $display("FAIL frz_state got %0d exp 2", bus.o_state); end
            if (bus.o_jump_landed_pulse !== 1'b0) begin n_fail++; $display("FAIL frz_lpulse got %b exp 0", bus.o_jump_landed_pulse); end
        end
        bus.i_freeze = 1'b0;
        cyc(1'b1);
        n_cmp += 4;
        if (bus.o_player_y !== 10'd184) begin n_fail++; $display("FAIL land_y got %0d exp 184", bus.o_player_y); end
        if (bus.o_vy !== 8'sd0) begin n_fail++; $display("FAIL land_vy got %0d exp 0", bus.o_vy); end
        if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL land_state got %0d exp 0", bus.o_state); end
        if (bus.o_jump_landed_pulse !== 1'b1) begin n_fail++; $display("FAIL land_lpulse got %b exp 1", bus.o_jump_landed_pulse); end
        cyc(1'b0);
        n_cmp++;
        if (bus.o_jump_landed_pulse !== 1'b0) begin n_fail++; $display("FAIL land_lpulse_width got %b exp 0", bus.o_jump_landed_pulse); end
    endtask

    task automatic test_bounds();
        int n;
        bus.i_move_left = 1'b1;
        n = 0;
        while (m_x != 0 && n < 400) begin cyc(1'b1); n++; end
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_player_x !== 10'd0) begin n_fail++; $display("FAIL left_sat_x got %0d exp 0", bus.o_player_x); end
        if (bus.o_vx !== 6'sd0) begin n_fail++; $display("FAIL left_sat_vx got %0d exp 0", bus.o_vx); end
        bus.i_move_left = 1'b0; bus.i_move_right = 1'b1; bus.i_hit_right_wall = 1'b1;
        cyc(1'b1);
        n_cmp++;
        if (bus.o_vx !== 6'sd0) begin n_fail++; $display("FAIL rwall_vx got %0d exp 0", bus.o_vx); end
        bus.i_hit_right_wall = 1'b0;
        cyc(1'b1);
        n_cmp += 2;
        if (bus.o_vx !== 6'sd1) begin n_fail++; $display("FAIL free_vx got %0d exp 1", bus.o_vx); end
        if (bus.o_player_x !== 10'd1) begin n_fail++; $display("FAIL free_x got %0d exp 1", bus.o_player_x); end
        bus.i_move_right = 1'b0;
    endtask

    task automatic test_reset_midjump();
        bus.i_jump = 1'b1;
        cyc(1'b1);
        bus.i_on_ground = 1'b0;
        repeat (2) cyc(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp += 6;
        if (bus.o_player_x !== 10'(START_X)) begin n_fail++; $display("FAIL mid_rst_x got %0d exp %0d", bus.o_player_x, START_X); end
        if (bus.o_player_y !== 10'(START_Y)) begin n_fail++; $display("FAIL mid_rst_y got %0d exp %0d", bus.o_player_y, START_Y); end
        if (bus.o_vy !== 8'sd0) begin n_fail++; $display("FAIL mid_rst_vy got %0d exp 0", bus.o_vy); end
        if (bus.o_vx !== 6'sd0) begin n_fail++; $display("FAIL mid_rst_vx got %0d exp 0", bus.o_vx); end
        if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state got %0d exp 0", bus.o_state); end
        if (bus.o_jump_start_pulse !== 1'b0 || bus.o_jump_landed_pulse !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_pulses got %b%b exp 00", bus.o_jump_start_pulse, bus.o_jump_landed_pulse);
        end
        m_reset();
        bus.i_jump = 1'b0; bus.i_on_ground = 1'b1; bus.i_support_y = 10'd360; bus.i_move_right = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1);
        n_cmp += 3;
        if (bus.o_vx !== 6'sd1) begin n_fail++; $display("FAIL post_rst_vx got %0d exp 1", bus.o_vx); end
        if (bus.o_player_x !== 10'd21) begin n_fail++; $display("FAIL post_rst_x got %0d exp 21", bus.o_player_x); end
        if (bus.o_player_y !== 10'd344) begin n_fail++; $display("FAIL post_rst_y got %0d exp 344", bus.o_player_y); end
        bus.i_move_right = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.i_move_left      = ($urandom_range(0, 2) == 0);
            bus.i_move_right     = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) bus.i_jump = ~bus.i_jump;
            if ($urandom_range(0, 5) == 0) bus.i_on_ground = ~bus.i_on_ground;
            if ($urandom_range(0, 15) == 0) bus.i_support_y = 10'($urandom_range(0, 700));
            bus.i_hit_ceiling    = ($urandom_range(0, 9) == 0);
            bus.i_hit_left_wall  = ($urandom_range(0, 9) == 0);
            bus.i_hit_right_wall = ($urandom_range(0, 9) == 0);
            bus.i_freeze         = ($urandom_range(0, 7) == 0);
            cyc(logic'($urandom_range(0, 2) != 0));
            n_cmp += 7;
            if (bus.o_player_x !== 10'(m_x)) begin n_fail++; $display("FAIL rnd_x i=%0d got %0d exp %0d", i, bus.o_player_x, m_x); end
            if (bus.o_player_y !== 10'(m_y)) begin n_fail++; $display("FAIL rnd_y i=%0d got %0d exp %0d", i, bus.o_player_y, m_y); end
            if (bus.o_vx !== 6'(m_vx)) begin n_fail++; $display("FAIL rnd_vx i=%0d got %0d exp %0d", i, bus.o_vx, m_vx); end
            if (bus.o_vy !== 8'(m_vy)) begin n_fail++; $display("FAIL rnd_vy i=%0d got %0d exp %0d", i, bus.o_vy, m_vy); end
            if (bus.o_state !== 2'(m_st)) begin n_fail++; $display("FAIL rnd_state i=%0d got %0d exp %0d", i, bus.o_state, m_st); end
            if (bus.o_jump_start_pulse !== m_sp) begin n_fail++; $display("FAIL rnd_spulse i=%0d got %b exp %b", i, bus.o_jump_start_pulse, m_sp); end
            if (bus.o_jump_landed_pulse !== m_lp) begin n_fail++; $display("FAIL rnd_lpulse i=%0d got %b exp %b", i, bus.o_jump_landed_pulse, m_lp); end
        end
        bus.i_freeze = 1'b0;
    endtask

    initial begin
        int apex_held;
        bus.i_game_tick = 1'b0; bus.i_move_left = 1'b0; bus.i_move_right = 1'b0;
        bus.i_jump = 1'b0; bus.i_on_ground = 1'b0; bus.i_support_y = 10'd360;
        bus.i_hit_ceiling = 1'b0; bus.i_hit_left_wall = 1'b0; bus.i_hit_right_wall = 1'b0;
        bus.i_freeze = 1'b0;
        m_reset();
        test_reset();
        test_walk();
        test_jump_held(apex_held);
        test_jump_tap(apex_held);
        test_coyote();
        test_landing();
        test_bounds();
        test_reset_midjump();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
